alu: RTL and testbench

- 8-bit datapath core: a 4-entry x 8-bit register file (sub-module `registers`) feeding a registered ALU.
- The ALU combines the register file read-bus value with an 8-bit immediate.
- The result `sum` is returned by the controller through `data_bus_in` for write-back.
- Sits under the instruction sequencer, which drives all enables and selects directly.

---
 rtl/alu_pkg.sv | 70 +++++++
 rtl/alu_if.sv | 39 +++
 rtl/alu_registers.sv | 31 +++
 rtl/alu.sv | 79 +++++++
 tb/tb_alu.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu datapath core: widths, ALU mode encodings,
// sequencer opcodes and the combinational ALU evaluation helper.
package alu_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int SEL_W    = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    MODE_ADD    = 3'b000,
    MODE_SUB    = 3'b001,
    MODE_PASS_A = 3'b010,
    MODE_PASS_B = 3'b011,
    MODE_AND    = 3'b100,
    MODE_OR     = 3'b101,
    MODE_XOR    = 3'b110,
    MODE_CMP    = 3'b111
  } alu_mode_e;

  // Opcodes issued by the instruction sequencer that drives this core.
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADDI  = 4'h3;
  localparam logic [3:0] OP_SUBI  = 4'h4;
  localparam logic [3:0] OP_ANDI  = 4'h5;
  localparam logic [3:0] OP_ORI   = 4'h6;
  localparam logic [3:0] OP_XORI  = 4'h7;
  localparam logic [3:0] OP_CMPI  = 4'h8;
  localparam logic [3:0] OP_MOVI  = 4'h9;
  localparam logic [3:0] OP_MOV   = 4'hA;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              zero;
    logic              carry;
    logic              hold_sum;   // compare leaves the result register untouched
  } alu_res_t;

  // a = immediate operand, b = register read-bus operand.
  function automatic alu_res_t alu_eval(alu_mode_e mode,
                                        logic [DATA_W-1:0] a,
                                        logic [DATA_W-1:0] b);
    alu_res_t      res;
    logic [DATA_W:0] add_w;
    logic [DATA_W:0] sub_w;
    add_w = {1'b0, b} + {1'b0, a};
    sub_w = {1'b0, b} - {1'b0, a};
    res = '0;
    case (mode)
      MODE_ADD:    begin res.sum = add_w[DATA_W-1:0]; res.carry = add_w[DATA_W]; end
      MODE_SUB:    begin res.sum = sub_w[DATA_W-1:0]; res.carry = sub_w[DATA_W]; end
      MODE_PASS_A: res.sum = a;
      MODE_PASS_B: res.sum = b;
      MODE_AND:    res.sum = b & a;
      MODE_OR:     res.sum = b | a;
      MODE_XOR:    res.sum = b ^ a;
      MODE_CMP:    begin
        res.sum      = sub_w[DATA_W-1:0];
        res.carry    = sub_w[DATA_W];
        res.hold_sum = 1'b1;
      end
      default:     res.sum = '0;
    endcase
    // Compare reports equality directly; every other mode flags a zero result.
    res.zero = res.hold_sum ? (b == a) : (res.sum == '0);
    return res;
  endfunction

endpackage

// File: rtl/alu_if.sv
// Sequencer-facing bus of the alu core: register file access plus ALU controls
// and results. Optional macro ALU_OVERFLOW_EN adds overflow_flag.
interface alu_if;
  import alu_pkg::*;

  logic [SEL_W-1:0]  register_select;
  logic              mem_enable;
  logic              read_write;
  logic [DATA_W-1:0] data_bus_in;
  logic [DATA_W-1:0] data_bus_out;
  logic              alu_enable;
  logic [2:0]        mode;
  logic [DATA_W-1:0] immediate_input;
  logic [DATA_W-1:0] sum;
  logic              zero_flag;
  logic              carry_flag;
`ifdef ALU_OVERFLOW_EN
  logic              overflow_flag;
`endif

  modport master (
    output register_select, mem_enable, read_write, data_bus_in,
    output alu_enable, mode, immediate_input,
`ifdef ALU_OVERFLOW_EN
    input  overflow_flag,
`endif
    input  data_bus_out, sum, zero_flag, carry_flag
  );

  modport slave (
    input  register_select, mem_enable, read_write, data_bus_in,
    input  alu_enable, mode, immediate_input,
`ifdef ALU_OVERFLOW_EN
    output overflow_flag,
`endif
    output data_bus_out, sum, zero_flag, carry_flag
  );

endinterface

// File: rtl/alu_registers.sv
// 4 x 8 register file with a registered read port; reads see the contents
// at the start of the cycle (no write-through).
module registers
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_en,
  input  logic              i_rd,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic [DATA_W-1:0] r_rdata;

  // Storage write and registered read; reset wins over any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else if (i_en) begin
      if (i_rd) r_rdata       <= r_mem[i_sel];
      else      r_mem[i_sel]  <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/alu.sv
// alu core: register file plus a registered ALU whose B operand is the
// registered read bus. Optional macro ALU_OVERFLOW_EN adds a signed overflow flag.
module alu
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  logic [DATA_W-1:0] w_rdata;
  alu_res_t          w_res;
  logic [DATA_W-1:0] r_sum;
  logic              r_zero;
  logic              r_carry;

  registers u_regs (
    .clk     (clk),
    .rst     (rst),
    .i_sel   (bus.register_select),
    .i_en    (bus.mem_enable),
    .i_rd    (bus.read_write),
    .i_wdata (bus.data_bus_in),
    .o_rdata (w_rdata)
  );

  assign w_res = alu_eval(alu_mode_e'(bus.mode), bus.immediate_input, w_rdata);

  // Result and flag registers; compare updates flags but keeps the old sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (bus.alu_enable) begin
      if (!w_res.hold_sum) r_sum <= w_res.sum;
      r_zero  <= w_res.zero;
      r_carry <= w_res.carry;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic [DATA_W-1:0] w_add;
  logic [DATA_W-1:0] w_sub;
  logic              w_ovf;
  logic              r_ovf;

  assign w_add = w_rdata + bus.immediate_input;
  assign w_sub = w_rdata - bus.immediate_input;

  // Signed overflow: add when operand signs match and result sign differs;
  // B-A when operand signs differ and result sign differs from B.
  always_comb begin
    w_ovf = 1'b0;
    case (alu_mode_e'(bus.mode))
      MODE_ADD: w_ovf = (w_rdata[DATA_W-1] == bus.immediate_input[DATA_W-1]) &&
                        (w_add[DATA_W-1]   != w_rdata[DATA_W-1]);
      MODE_SUB,
      MODE_CMP: w_ovf = (w_rdata[DATA_W-1] != bus.immediate_input[DATA_W-1]) &&
                        (w_sub[DATA_W-1]   != w_rdata[DATA_W-1]);
      default:  w_ovf = 1'b0;
    endcase
  end

  // Overflow flag updates alongside the other flags.
  always_ff @(posedge clk) begin
    if (rst)                 r_ovf <= 1'b0;
    else if (bus.alu_enable) r_ovf <= w_ovf;
  end

  assign bus.overflow_flag = r_ovf;
`endif

  assign bus.data_bus_out = w_rdata;
  assign bus.sum          = r_sum;
  assign bus.zero_flag    = r_zero;
  assign bus.carry_flag   = r_carry;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the alu core: table of single ALU operations with a
// scoreboard queue, plus hand sequences for same-cycle read/ALU, holds and reset.
module tb_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_if bus();
  alu u_dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [7:0] reg_val;
    logic [7:0] imm;
    logic [2:0] mode;
    logic [7:0] e_sum;
    logic       e_z;
    logic       e_c;
    logic       e_v;
  } vec_t;

  typedef struct packed {
    logic [7:0] sum;
    logic       z;
    logic       c;
    logic       v;
  } exp_t;

  vec_t vecs [16];
  exp_t sb_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [7:0] s, input logic z, input logic c, input logic v);
    exp_t e;
    e = '{sum: s, z: z, c: c, v: v};
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got sum %02h expected an entry", tag, bus.sum);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".sum"}, bus.sum, e.sum);
      chk({tag, ".z"}, {7'b0, bus.zero_flag}, {7'b0, e.z});
      chk({tag, ".c"}, {7'b0, bus.carry_flag}, {7'b0, e.c});
`ifdef ALU_OVERFLOW_EN
      chk({tag, ".v"}, {7'b0, bus.overflow_flag}, {7'b0, e.v});
`endif
    end
  endtask

  task automatic drive(input logic men, input logic rw, input logic [1:0] sel,
                       input logic [7:0] din, input logic aen, input logic [2:0] md,
                       input logic [7:0] imm);
    bus.mem_enable      = men;
    bus.read_write      = rw;
    bus.register_select = sel;
    bus.data_bus_in     = din;
    bus.alu_enable      = aen;
    bus.mode            = md;
    bus.immediate_input = imm;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //             reg    imm    mode    sum    z     c     v
    vecs[0]  = '{8'h29, 8'h07, 3'b100, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h29, 8'h07, 3'b000, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h29, 8'h07, 3'b101, 8'h2F, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h29, 8'h07, 3'b110, 8'h2E, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h05, 8'h07, 3'b001, 8'hFE, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{8'h29, 8'h07, 3'b001, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{8'h29, 8'h07, 3'b000, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h07, 8'h07, 3'b111, 8'h30, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h07, 8'h08, 3'b111, 8'h30, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{8'h29, 8'h07, 3'b010, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'h29, 8'h07, 3'b011, 8'h29, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'h80, 8'h80, 3'b000, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{8'h00, 8'h01, 3'b001, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{8'h80, 8'h01, 3'b001, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{8'h7F, 8'h01, 3'b000, 8'h80, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 3'b000, 8'h00);
    @(negedge clk);
    tick();
    tick();
    chk("reset.sum", bus.sum, 8'h00);
    chk("reset.dbo", bus.data_bus_out, 8'h00);
    chk("reset.z", {7'b0, bus.zero_flag}, 8'h00);
    chk("reset.c", {7'b0, bus.carry_flag}, 8'h00);
    rst = 1'b0;

    // Table: write, read back, then one ALU edge using the fresh read value.
    for (int i = 0; i < 16; i++) begin
      logic [1:0] sel;
      sel = 2'(i % 4);
      drive(1'b1, 1'b0, sel, vecs[i].reg_val, 1'b0, 3'b000, 8'h00);
      tick();
      drive(1'b1, 1'b1, sel, 8'h00, 1'b0, 3'b000, 8'h00);
      tick();
      chk($sformatf("vec%0d.rd", i), bus.data_bus_out, vecs[i].reg_val);
      drive(1'b0, 1'b1, sel, 8'h00, 1'b1, vecs[i].mode, vecs[i].imm);
      sb_push(vecs[i].e_sum, vecs[i].e_z, vecs[i].e_c, vecs[i].e_v);
      tick();
      bus.alu_enable = 1'b0;
      sb_check($sformatf("vec%0d", i));
    end

    // Same-cycle read and ALU: first edge uses the stale bus value (F0).
    drive(1'b1, 1'b0, 2'd2, 8'hF0, 1'b0, 3'b000, 8'h00);
    tick();
    drive(1'b1, 1'b1, 2'd2, 8'h00, 1'b0, 3'b000, 8'h00);
    tick();
    drive(1'b1, 1'b0, 2'd0, 8'h29, 1'b0, 3'b000, 8'h00);
    tick();
    chk("wr_hold.dbo", bus.data_bus_out, 8'hF0);
    drive(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 3'b100, 8'h07);
    sb_push(8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    sb_check("same_cyc1");
    chk("same_cyc1.dbo", bus.data_bus_out, 8'h29);
    sb_push(8'h01, 1'b0, 1'b0, 1'b0);
    tick();
    sb_check("same_cyc2");
    drive(1'b1, 1'b0, 2'd1, 8'h01, 1'b0, 3'b000, 8'h00);
    tick();
    drive(1'b1, 1'b1, 2'd1, 8'h00, 1'b0, 3'b000, 8'h00);
    tick();
    chk("wb_reg1", bus.data_bus_out, 8'h01);

    // Holds: both enables low, inputs wiggled, a write attempt ignored.
    drive(1'b0, 1'b0, 2'd1, 8'hEE, 1'b0, 3'b000, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold%0d.dbo", k), bus.data_bus_out, 8'h01);
      chk($sformatf("hold%0d.sum", k), bus.sum, 8'h01);
      chk($sformatf("hold%0d.zc", k), {6'b0, bus.zero_flag, bus.carry_flag}, 8'h00);
    end
    drive(1'b1, 1'b1, 2'd1, 8'h00, 1'b0, 3'b000, 8'h00);
    tick();
    chk("no_wr_reg1", bus.data_bus_out, 8'h01);

    // Reset mid-operation with a pending write and ALU enable.
    drive(1'b1, 1'b0, 2'd1, 8'hAA, 1'b1, 3'b000, 8'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid.sum", bus.sum, 8'h00);
    chk("rst_mid.dbo", bus.data_bus_out, 8'h00);
    chk("rst_mid.zc", {6'b0, bus.zero_flag, bus.carry_flag}, 8'h00);
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, 1'b1, 2'(r), 8'h00, 1'b0, 3'b000, 8'h00);
      tick();
      chk($sformatf("rst_reg%0d", r), bus.data_bus_out, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
